// File: rtl/risc_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, datapath width,
// sequential PC increment and default memory timeout.
package risc_pkg;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    ISSUE      = 2'd2
  } fetch_state_e;

  localparam int DATA_WIDTH     = 32;
  localparam int PC_INC         = 4;
  localparam int TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC: sequential or branch target, forced to word
// alignment, with a flag when the raw target was not word aligned.
module pc_next
  import risc_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [W-1:0] pc,
  input  logic [W-1:0] imm_op,
  input  logic         branch_taken,
  output logic [W-1:0] target,
  output logic         misaligned
);

  logic [W-1:0] sum;

  // Plain W-bit add: overflow wraps modulo 2^W by construction.
  assign sum        = pc + (branch_taken ? imm_op : W'(PC_INC));
  assign misaligned = |sum[1:0];
  assign target     = {sum[W-1:2], 2'b00};

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: requests a word at pc, holds it for decode until
// the downstream stage accepts it, then steps or branches to the next pc.
module pc_fetch
  import risc_pkg::*;
#(
  parameter int                    Data_Width     = DATA_WIDTH,
  parameter logic [Data_Width-1:0] Reset_Vector   = '0,
  parameter int                    Timeout_Cycles = TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_taken,
  input  logic [Data_Width-1:0] imm_op,
  input  logic                  stall,
  input  logic [Data_Width-1:0] imem_rdata,
  input  logic                  imem_valid,
  output logic                  imem_req,
  output logic [Data_Width-1:0] imem_addr,
  output logic [Data_Width-1:0] pc,
  output logic [Data_Width-1:0] instr,
  output logic                  instr_valid,
  output logic                  fetch_err,
  output fetch_state_e          fsm_state
);

  // Handshakes: memory side is req/valid (valid only counts while imem_req=1);
  // decode side is instr_valid/!stall (the word is consumed on the cycle
  // instr_valid=1 and stall=0, and only then are branch_taken/imm_op used).

  localparam int CW = $clog2(Timeout_Cycles + 1);

  fetch_state_e          state_q, state_d;
  logic [Data_Width-1:0] pc_q, pc_d;
  logic [Data_Width-1:0] instr_q, instr_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [Data_Width-1:0] target;
  logic                  misaligned;

  pc_next #(.W(Data_Width)) u_pc_next (
    .pc           (pc_q),
    .imm_op       (imm_op),
    .branch_taken (branch_taken),
    .target       (target),
    .misaligned   (misaligned)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      RESET_WAIT: state_d = FETCH;
      FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = ISSUE;
        end else if (cnt_q == CW'(Timeout_Cycles - 1)) begin
          // Flag the slow memory but keep requesting the same address.
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        if (!stall) begin
          pc_d    = target;
          err_d   = err_q | misaligned;
          state_d = FETCH;
        end
      end
      default: state_d = RESET_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_WAIT;
      pc_q    <= Reset_Vector;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ISSUE);
  assign fetch_err   = err_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed vector table, hand-written reset/timeout/
// misalignment sequences, then random transactions against a reference model.
module tb_pc_fetch;
  import risc_pkg::*;

  localparam int          TO = 15;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         branch_taken;
  logic [31:0]  imm_op;
  logic         stall;
  logic [31:0]  imem_rdata;
  logic         imem_valid;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic         instr_valid;
  logic         fetch_err;
  fetch_state_e fsm_state;

  pc_fetch #(.Data_Width(32), .Reset_Vector(RV), .Timeout_Cycles(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .imm_op       (imm_op),
    .stall        (stall),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .fetch_err    (fetch_err),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: address of the instruction being fetched and the
  // sticky error, plus the words delivered but not yet seen on instr.
  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] exp_q[$];

  typedef struct {
    int          w;
    int          s;
    bit          br;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    bit          exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with imem_valid asserted throughout, including the one post-reset
  // cycle, so any stray valid must be dropped.
  task automatic do_reset();
    rst_n        = 1'b0;
    imem_valid   = 1'b1;
    imem_rdata   = $urandom;
    stall        = 1'($urandom_range(0, 1));
    branch_taken = 1'($urandom_range(0, 1));
    imm_op       = $urandom;
    step();
    step();
    chk("rst_pc", pc, RV);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ivalid", {31'b0, instr_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    rst_n = 1'b1;
    imem_rdata = $urandom;
    chk("rwait_state", {30'b0, fsm_state}, {30'b0, RESET_WAIT});
    step();
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, RV);
    chk("post_rst_ivalid", {31'b0, instr_valid}, 32'h0);
    chk("post_rst_instr", instr, 32'h0);
    imem_valid = 1'b0;
    stall      = 1'b0;
    m_pc       = RV;
    m_err      = 1'b0;
    exp_q.delete();
  endtask

  // One instruction: w cycles without data, then data, then s stalled issue
  // cycles, then release with the given branch decision.
  task automatic run_txn(input int w, input int s, input bit br,
                         input logic [31:0] imm, input logic [31:0] rdata);
    logic [31:0] exp_instr;
    logic [32:0] t;
    for (int i = 0; i < w; i++) begin
      chk("fetch_req", {31'b0, imem_req}, 32'h1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_ivalid", {31'b0, instr_valid}, 32'h0);
      chk("fetch_err_wait", {31'b0, fetch_err}, {31'b0, (m_err | (i >= TO))});
      imem_valid   = 1'b0;
      imem_rdata   = $urandom;
      branch_taken = 1'($urandom_range(0, 1));
      imm_op       = $urandom;
      step();
    end
    if (w >= TO) m_err = 1'b1;
    chk("fetch_req", {31'b0, imem_req}, 32'h1);
    chk("fetch_addr", imem_addr, m_pc);
    imem_valid = 1'b1;
    imem_rdata = rdata;
    exp_q.push_back(rdata);
    step();
    exp_instr = exp_q.pop_front();
    for (int j = 0; j <= s; j++) begin
      chk("issue_ivalid", {31'b0, instr_valid}, 32'h1);
      chk("issue_instr", instr, exp_instr);
      chk("issue_pc", pc, m_pc);
      chk("issue_req", {31'b0, imem_req}, 32'h0);
      chk("issue_err", {31'b0, fetch_err}, {31'b0, m_err});
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      if (j < s) begin
        stall        = 1'b1;
        branch_taken = 1'($urandom_range(0, 1));
        imm_op       = $urandom;
      end else begin
        stall        = 1'b0;
        branch_taken = br;
        imm_op       = imm;
      end
      step();
    end
    t = {1'b0, m_pc} + {1'b0, (br ? imm : 32'd4)};
    if (t[1:0] != 2'b00) m_err = 1'b1;
    m_pc = t[31:0] & 32'hFFFF_FFFC;
    imem_valid = 1'b0;
    stall      = 1'b0;
    chk("next_ivalid", {31'b0, instr_valid}, 32'h0);
    chk("next_req", {31'b0, imem_req}, 32'h1);
    chk("next_addr", imem_addr, m_pc);
    chk("next_err", {31'b0, fetch_err}, {31'b0, m_err});
  endtask

  initial begin
    int w;
    int s;
    rst_n        = 1'b0;
    branch_taken = 1'b0;
    imm_op       = '0;
    stall        = 1'b0;
    imem_rdata   = '0;
    imem_valid   = 1'b0;

    tbl[0] = '{0, 0, 1'b0, 32'h0,         32'hA000_0001, 32'h0000_0004, 1'b0};
    tbl[1] = '{0, 0, 1'b0, 32'h0,         32'hA000_0002, 32'h0000_0008, 1'b0};
    tbl[2] = '{0, 0, 1'b0, 32'h0,         32'hA000_0003, 32'h0000_000C, 1'b0};
    tbl[3] = '{0, 0, 1'b1, 32'h4,         32'hA000_0004, 32'h0000_0010, 1'b0};
    tbl[4] = '{1, 0, 1'b1, 32'hFFFF_FFF8, 32'hA000_0005, 32'h0000_0008, 1'b0};
    tbl[5] = '{0, 3, 1'b0, 32'h0,         32'hA000_0006, 32'h0000_000C, 1'b0};
    tbl[6] = '{2, 1, 1'b1, 32'hFFFF_FFF0, 32'hA000_0007, 32'hFFFF_FFFC, 1'b0};
    tbl[7] = '{0, 0, 1'b0, 32'h0,         32'hA000_0008, 32'h0000_0000, 1'b0};

    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_txn(tbl[k].w, tbl[k].s, tbl[k].br, tbl[k].imm, tbl[k].rdata);
      chk("tbl_pc", imem_addr, tbl[k].exp_pc);
      chk("tbl_err", {31'b0, fetch_err}, {31'b0, tbl[k].exp_err});
    end

    // Memory silent for exactly the timeout, then answers late.
    run_txn(TO, 0, 1'b0, 32'h0, 32'hB000_0001);
    chk("timeout_err", {31'b0, fetch_err}, 32'h1);
    chk("timeout_next_pc", imem_addr, 32'h0000_0004);
    run_txn(0, 0, 1'b0, 32'h0, 32'hB000_0002);
    chk("err_sticky", {31'b0, fetch_err}, 32'h1);

    // Reset while waiting in FETCH.
    imem_valid = 1'b0;
    step();
    step();
    do_reset();

    // Branch to a misaligned target.
    run_txn(0, 0, 1'b1, 32'h6, 32'hC000_0001);
    chk("misalign_pc", imem_addr, 32'h0000_0004);
    chk("misalign_err", {31'b0, fetch_err}, 32'h1);

    // Reset while an instruction is held in ISSUE.
    imem_valid = 1'b1;
    imem_rdata = 32'hD000_0001;
    step();
    chk("pre_rst_ivalid", {31'b0, instr_valid}, 32'h1);
    stall = 1'b1;
    do_reset();

    for (int n = 0; n < 40; n++) begin
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 5) : $urandom_range(0, 3);
      s = $urandom_range(0, 3);
      run_txn(w, s, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)) - 32'd32, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
